// File: rtl/sevseg_pkg.sv
// Shared constants and helpers for the seven-segment scanner.
package sevseg_pkg;

  // All segments off (segments are active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex nibble to active-low segment pattern, bit6 = a ... bit0 = g.
  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  // Width of the digit index; a single-digit display still needs one bit.
  function automatic int digitIdxWidth(input int numDigits);
    return (numDigits > 1) ? $clog2(numDigits) : 1;
  endfunction

endpackage

// File: rtl/sevseg_hex_decode.sv
// Combinational nibble-to-segment decoder.
module sevseg_hex_decode
  import sevseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = hex2seg(i_nibble);

endmodule

// File: rtl/sevseg_scan.sv
// Tear-free multiplexed seven-segment scanner with shadow capture,
// per-digit enable, leading-zero blanking and PWM brightness.
module sevseg_scan
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SLOT_CYCLES = 50000,
  parameter int DUTY_BITS   = 3
)
(
  input  logic                    clk,
  input  logic                    Rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [DUTY_BITS-1:0]    bright,
  output logic [6:0]              sev_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IW = digitIdxWidth(NUM_DIGITS);
  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int PW = $clog2(SLOT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] SLICE    = PW'(SLOT_CYCLES >> DUTY_BITS);

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_digitEn;
  logic                    r_blankLz;
  logic [6:0]              r_sevOut;
  logic                    r_dpOut;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frameTick;

  logic                    w_slotEnd;
  logic                    w_capture;
  logic [3:0]              w_nibble;
  logic                    w_dpSel;
  logic                    w_enSel;
  logic                    w_lzSel;
  logic [NUM_DIGITS-1:0]   w_lzBlank;
  logic                    w_zeroRun;
  logic [PW-1:0]           w_thresh;
  logic                    w_lit;
  logic                    w_show;
  logic [6:0]              w_seg;

  assign w_slotEnd = (r_cnt == CNT_LAST);
  assign w_capture = w_slotEnd && (r_idx == IDX_LAST);

  // Slot cycle counter and digit index; the index steps once per slot.
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slotEnd) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Shadow copy of the display data, refreshed only at the end of a frame.
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_value   <= '0;
      r_dp      <= '0;
      r_digitEn <= '1;
      r_blankLz <= 1'b0;
    end else if (w_capture) begin
      r_value   <= value;
      r_dp      <= dp;
      r_digitEn <= digit_en;
      r_blankLz <= blank_lz;
    end
  end

  // Pick the shadowed nibble and flags belonging to the current digit.
  always_comb begin
    w_nibble = 4'd0;
    w_dpSel  = 1'b0;
    w_enSel  = 1'b0;
    w_lzSel  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nibble = r_value[4*i +: 4];
        w_dpSel  = r_dp[i];
        w_enSel  = r_digitEn[i];
        w_lzSel  = w_lzBlank[i];
      end
    end
  end

  // Leading zeros: walk down from the top digit while nibble and dp are clear.
  always_comb begin
    w_lzBlank = '0;
    w_zeroRun = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zeroRun    = w_zeroRun & (r_value[4*i +: 4] == 4'd0) & ~r_dp[i];
      w_lzBlank[i] = r_blankLz & w_zeroRun & (i > 0);
    end
  end

  assign w_thresh = (PW'(bright) + PW'(1)) * SLICE;
  assign w_lit    = (PW'(r_cnt) < w_thresh);
  assign w_show   = w_lit && w_enSel && !w_lzSel;

  sevseg_hex_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Registered display outputs and frame start pulse.
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_an        <= '1;
      r_sevOut    <= SEG_BLANK;
      r_dpOut     <= 1'b1;
      r_frameTick <= 1'b0;
    end else begin
      r_frameTick <= (r_idx == '0) && (r_cnt == '0);
      if (w_show) begin
        r_an     <= ~(NUM_DIGITS'(1) << r_idx);
        r_sevOut <= w_seg;
        r_dpOut  <= ~w_dpSel;
      end else begin
        r_an     <= '1;
        r_sevOut <= SEG_BLANK;
        r_dpOut  <= 1'b1;
      end
    end
  end

  assign an         = r_an;
  assign sev_out    = r_sevOut;
  assign dp_out     = r_dpOut;
  assign frame_tick = r_frameTick;

endmodule

// File: tb/tb_sevseg_scan.sv
// Directed self-checking bench for sevseg_scan (4 digits, 8-cycle slots).
module tb_sevseg_scan;

  logic        clk;
  logic        Rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic [1:0]  bright;
  logic [6:0]  sev_out;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_tick;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Segment patterns used by the vectors below.
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b1100000;
  localparam logic [6:0] SC = 7'b0110001;
  localparam logic [6:0] SD = 7'b1000010;

  sevseg_scan #(
    .NUM_DIGITS  (4),
    .SLOT_CYCLES (8),
    .DUTY_BITS   (2)
  ) dut (
    .clk        (clk),
    .Rst        (Rst),
    .value      (value),
    .dp         (dp),
    .digit_en   (digit_en),
    .blank_lz   (blank_lz),
    .bright     (bright),
    .sev_out    (sev_out),
    .dp_out     (dp_out),
    .an         (an),
    .frame_tick (frame_tick)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive all data inputs in one go.
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en,
                               input logic lz, input logic [1:0] br);
    value    = v;
    dp       = d;
    digit_en = en;
    blank_lz = lz;
    bright   = br;
  endtask

  // Advance to the next negedge at which frame_tick is high, bounded.
  task automatic waitFrameTick();
    bit seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) seen = 1;
    end
    if (!seen) checkOutput("frameTickTimeout", 32'd0, 32'd1);
  endtask

  // Check one whole frame from its frame_tick negedge onward.
  task automatic checkFrame(input string name, input logic [27:0] segs, input logic [3:0] shown,
                            input logic [3:0] dpOn, input int litCycles);
    logic       on;
    logic [3:0] expAn;
    logic [6:0] expSeg;
    logic       expDp;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 8; k++) begin
        on     = shown[d] && (k < litCycles);
        expAn  = on ? ~(4'b0001 << d) : 4'hF;
        expSeg = on ? segs[7*d +: 7] : 7'h7F;
        expDp  = on ? ~dpOn[d] : 1'b1;
        checkOutput($sformatf("%s an d%0d k%0d", name, d, k), 32'(an), 32'(expAn));
        checkOutput($sformatf("%s seg d%0d k%0d", name, d, k), 32'(sev_out), 32'(expSeg));
        checkOutput($sformatf("%s dp d%0d k%0d", name, d, k), 32'(dp_out), 32'(expDp));
        checkOutput($sformatf("%s tick d%0d k%0d", name, d, k), 32'(frame_tick),
                    32'((d == 0 && k == 0) ? 1 : 0));
        @(negedge clk);
      end
    end
  endtask

  // Directed scenario sequence.
  initial begin
    Rst = 1'b1;
    applyStimulus(16'h0000, 4'b0000, 4'b1111, 1'b0, 2'd3);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst an", 32'(an), 32'hF);
    checkOutput("rst seg", 32'(sev_out), 32'h7F);
    checkOutput("rst dp", 32'(dp_out), 32'd1);
    checkOutput("rst tick", 32'(frame_tick), 32'd0);

    // First cycle after release shows digit 0 as "0" with frame_tick.
    Rst = 1'b0;
    @(negedge clk);
    checkOutput("rel tick", 32'(frame_tick), 32'd1);
    checkOutput("rel an", 32'(an), 32'hE);
    checkOutput("rel seg", 32'(sev_out), 32'(S0));

    // Plain scan of 1234 at full brightness.
    applyStimulus(16'h1234, 4'b0000, 4'b1111, 1'b0, 2'd3);
    waitFrameTick();
    checkFrame("scan", {S1, S2, S3, S4}, 4'b1111, 4'b0000, 8);

    // Leading-zero blanking of 0050.
    applyStimulus(16'h0050, 4'b0000, 4'b1111, 1'b1, 2'd3);
    waitFrameTick();
    checkFrame("lz", {S0, S0, S5, S0}, 4'b0011, 4'b0000, 8);

    // A decimal point on digit 3 stops all blanking.
    applyStimulus(16'h0050, 4'b1000, 4'b1111, 1'b1, 2'd3);
    waitFrameTick();
    checkFrame("lzdp", {S0, S0, S5, S0}, 4'b1111, 4'b1000, 8);

    // Dimmest brightness: two lit cycles per slot.
    applyStimulus(16'h1234, 4'b0000, 4'b1111, 1'b0, 2'd0);
    waitFrameTick();
    checkFrame("dim", {S1, S2, S3, S4}, 4'b1111, 4'b0000, 2);

    // Mid-frame change must not tear the frame currently on display.
    applyStimulus(16'h1234, 4'b0000, 4'b1111, 1'b0, 2'd3);
    waitFrameTick();
    fork
      checkFrame("tear", {S1, S2, S3, S4}, 4'b1111, 4'b0000, 8);
      begin
        repeat (12) @(negedge clk);
        value    = 16'hABCD;
        digit_en = 4'b1011;
      end
    join
    checkFrame("enable", {SA, SB, SC, SD}, 4'b1011, 4'b0000, 8);

    // Reset in the middle of the digit 2 slot.
    applyStimulus(16'h1234, 4'b0000, 4'b1111, 1'b0, 2'd3);
    waitFrameTick();
    repeat (18) @(negedge clk);
    checkOutput("mid pre an", 32'(an), 32'hB);
    Rst = 1'b1;
    @(negedge clk);
    checkOutput("mid rst an", 32'(an), 32'hF);
    checkOutput("mid rst seg", 32'(sev_out), 32'h7F);
    checkOutput("mid rst dp", 32'(dp_out), 32'd1);
    checkOutput("mid rst tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    Rst = 1'b0;
    @(negedge clk);
    checkOutput("mid rel tick", 32'(frame_tick), 32'd1);
    checkOutput("mid rel an", 32'(an), 32'hE);
    checkOutput("mid rel seg", 32'(sev_out), 32'(S0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
